// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with whole-frame debounce and one-cycle key strobe.
// Optional macro KEYPAD_AUTO_REPEAT_EN adds held-key auto-repeat strobes.
module keypad_scan_debounce #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_FRAMES  = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] ckey,
   output logic [3:0] rkey,
   output logic [3:0] key_code,
   output logic       key_stb,
   output logic       key_held
);
   localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [3:0]    DB_N     = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_t;

   logic [3:0]    sync1, sync2;
   logic [DW-1:0] div_cnt;
   logic [1:0]    row;
   logic [1:0]    acc_n, row_n, tot_n, row_col;
   logic [2:0]    sum_n;
   logic [3:0]    acc_code, res_code;
   logic          sample, frame_end;

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx, cand, cand_nx, code_nx;
   logic       stb_nx, held_nx;

   assign sample    = (div_cnt == DIV_LAST);
   assign frame_end = sample && (row == 2'd3);
   assign rkey      = ~(4'b0001 << row);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 4'hF;
         sync2 <= 4'hF;
      end else begin
         sync1 <= ckey;
         sync2 <= sync1;
      end
   end

   // Zero-bit count saturates at 2: anything beyond one key is just MULTI.
   always_comb begin
      row_n   = 2'd0;
      row_col = 2'd0;
      for (int c = 0; c < 4; c++) begin
         if (!sync2[c]) begin
            row_col = 2'(c);
            if (row_n != 2'd2) row_n = row_n + 2'd1;
         end
      end
      sum_n    = {1'b0, acc_n} + {1'b0, row_n};
      tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
      res_code = acc_code;
      if (acc_n == 2'd0 && row_n == 2'd1) res_code = {row, row_col};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt  <= '0;
         row      <= 2'd0;
         acc_n    <= 2'd0;
         acc_code <= 4'd0;
      end else if (sample) begin
         div_cnt <= '0;
         row     <= row + 2'd1;
         if (frame_end) begin
            acc_n    <= 2'd0;
            acc_code <= 4'd0;
         end else begin
            acc_n    <= tot_n;
            acc_code <= res_code;
         end
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

`ifdef KEYPAD_AUTO_REPEAT_EN
   localparam int RW = $clog2(2 * REPEAT_FRAMES + 1);
   logic [RW-1:0] rep_cnt, rep_nx;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rep_cnt <= '0;
      else      rep_cnt <= rep_nx;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         cand     <= 4'd0;
         key_code <= 4'd0;
         key_stb  <= 1'b0;
         key_held <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         cand     <= cand_nx;
         key_code <= code_nx;
         key_stb  <= stb_nx;
         key_held <= held_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cand_nx  = cand;
      code_nx  = key_code;
      stb_nx   = 1'b0;
      held_nx  = key_held;
      if (frame_end) begin
         case (state)
            IDLE: begin
               if (tot_n == 2'd1) begin
                  state_nx = PRESS_DB;
                  cand_nx  = res_code;
                  cnt_nx   = 4'd1;
               end
            end
            PRESS_DB: begin
               if (tot_n == 2'd1 && res_code == cand) begin
                  cnt_nx = cnt + 4'd1;
               end else if (tot_n == 2'd1) begin
                  cand_nx = res_code;
                  cnt_nx  = 4'd1;
               end else begin
                  state_nx = IDLE;
                  cnt_nx   = 4'd0;
               end
            end
            PRESSED: begin
               if (tot_n == 2'd0) begin
                  state_nx = REL_DB;
                  cnt_nx   = 4'd1;
               end
            end
            REL_DB: begin
               if (tot_n == 2'd0) begin
                  cnt_nx = cnt + 4'd1;
               end else begin
                  state_nx = PRESSED;
                  cnt_nx   = 4'd0;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = 4'd0;
            end
         endcase
         // Threshold test after the count update so DEBOUNCE_SCANS=1 accepts on the first frame.
         if (state_nx == PRESS_DB && cnt_nx >= DB_N) begin
            state_nx = PRESSED;
            cnt_nx   = 4'd0;
            code_nx  = cand_nx;
            stb_nx   = 1'b1;
            held_nx  = 1'b1;
         end else if (state_nx == REL_DB && cnt_nx >= DB_N) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
            held_nx  = 1'b0;
         end
      end
`ifdef KEYPAD_AUTO_REPEAT_EN
      rep_nx = rep_cnt;
      if (state_nx != PRESSED) begin
         rep_nx = '0;
      end else if (frame_end && state == PRESSED) begin
         if (rep_cnt + RW'(1) == RW'(2 * REPEAT_FRAMES)) begin
            rep_nx = RW'(REPEAT_FRAMES);
            stb_nx = 1'b1;
         end else begin
            rep_nx = rep_cnt + RW'(1);
         end
      end
`endif
   end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: keypad matrix model, directed frame table, random frames vs model.
module tb_keypad_scan_debounce;
   localparam int SD = 4, DB = 3, RF = 2;

   logic       clk = 1'b0, rst = 1'b0;
   logic [3:0] ckey, rkey, key_code;
   logic       key_stb, key_held;
   logic [15:0] keys = 16'h0;
   logic       force_en = 1'b1;
   logic [3:0] force_val = 4'hF;
   int checks = 0, failures = 0;

   keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_FRAMES(RF)) dut (
      .clk(clk), .rst(rst), .ckey(ckey), .rkey(rkey),
      .key_code(key_code), .key_stb(key_stb), .key_held(key_held));

   always #5 clk = ~clk;

   // Matrix: a pressed key pulls its column low only while its row is driven low.
   always_comb begin
      ckey = 4'hF;
      if (force_en) ckey = force_val;
      else
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               if (!rkey[r] && keys[r*4+c]) ckey[c] = 1'b0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: counts of consecutive qualifying frames and frames held since acceptance.
   bit m_held; int m_run, m_cand, m_rel, m_since; logic [3:0] m_code;

   function automatic void model_reset();
      m_held = 0; m_run = 0; m_cand = -1; m_rel = 0; m_since = 0; m_code = 4'd0;
   endfunction

   function automatic int model_frame(input logic [15:0] k);
      int n, c, s;
      n = $countones(k); c = -1; s = 0;
      for (int i = 0; i < 16; i++) if (k[i]) c = i;
      if (!m_held) begin
         if (n == 1) begin
            if (m_run > 0 && c == m_cand) m_run++;
            else begin m_run = 1; m_cand = c; end
            if (m_run >= DB) begin
               m_held = 1; m_code = 4'(m_cand); m_run = 0; m_rel = 0; m_since = 0; s = 1;
            end
         end else m_run = 0;
      end else if (n == 0) begin
         m_rel++; m_since = 0;
         if (m_rel >= DB) begin m_held = 0; m_rel = 0; end
      end else if (m_rel > 0) begin
         m_rel = 0; m_since = 0;
      end else begin
         m_since++;
`ifdef KEYPAD_AUTO_REPEAT_EN
         if (m_since >= 2*RF && (m_since - 2*RF) % RF == 0) s = 1;
`endif
      end
      return s;
   endfunction

   task automatic run_frame(input logic [15:0] k, input bit walk, output int nstb, output logic [3:0] scode);
      logic [3:0] exp_r;
      keys = k; nstb = 0; scode = 4'd0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); @(negedge clk);
         if (walk) begin
            exp_r = ~(4'b0001 << ((i / 4) % 4));
            chk("rkey_walk", rkey, exp_r);
         end
         if (key_stb) begin nstb++; scode = key_code; end
      end
   endtask

   typedef struct { logic [15:0] k; int stb; logic held; logic [3:0] code; } vec_t;
   vec_t tbl[$];

   task automatic add(input logic [15:0] k, input int n, input int s, input logic h, input logic [3:0] c);
      vec_t v;
      v.k = k; v.stb = s; v.held = h; v.code = c;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ns, tot, e; logic [3:0] sc; logic [15:0] p; int a, b, len;
      model_reset();
      // Reset with column inputs toggling
      for (int i = 0; i < 6; i++) begin @(negedge clk); force_val = force_val ^ 4'b0101; end
      chk("rst_rkey", rkey, 4'b1110);
      chk("rst_stb", key_stb, 0);
      chk("rst_held", key_held, 0);
      chk("rst_code", key_code, 0);
      force_en = 1'b0;
      @(negedge clk); rst = 1'b1;
      run_frame(16'h0, 1'b1, ns, sc);
      chk("idle_stb", ns, 0);

      // Directed frames: {keys, frames, strobes/frame, held, code at frame end}
      add(16'h0200, 2, 0, 0, 4'd0); add(16'h0200, 1, 1, 1, 4'd9); add(16'h0200, 2, 0, 1, 4'd9);
      add(16'h0000, 2, 0, 1, 4'd9); add(16'h0000, 1, 0, 0, 4'd9);
      add(16'h0001, 2, 0, 0, 4'd9); add(16'h0001, 1, 1, 1, 4'd0);
      add(16'h0000, 2, 0, 1, 4'd0); add(16'h0001, 2, 0, 1, 4'd0);
      add(16'h0000, 2, 0, 1, 4'd0); add(16'h0000, 1, 0, 0, 4'd0);
      add(16'h0008, 2, 0, 0, 4'd0); add(16'h0000, 1, 0, 0, 4'd0);
      add(16'h0008, 2, 0, 0, 4'd0); add(16'h0008, 1, 1, 1, 4'd3);
      add(16'h0000, 2, 0, 1, 4'd3); add(16'h0000, 1, 0, 0, 4'd3);
      add(16'h0060, 6, 0, 0, 4'd3); add(16'h0000, 1, 0, 0, 4'd3);
      add(16'h0010, 1, 0, 0, 4'd3); add(16'h0080, 2, 0, 0, 4'd3); add(16'h0080, 1, 1, 1, 4'd7);
      add(16'h0004, 1, 0, 1, 4'd7);
      add(16'h0000, 2, 0, 1, 4'd7); add(16'h0000, 1, 0, 0, 4'd7);
      foreach (tbl[i]) begin
         e = model_frame(tbl[i].k);
         run_frame(tbl[i].k, 1'b0, ns, sc);
         chk("tbl_stb", ns, tbl[i].stb);
         chk("tbl_held", key_held, tbl[i].held);
         chk("tbl_code", key_code, tbl[i].code);
      end

      // Reset in the middle of a debounce must discard the partial count
      run_frame(16'h1000, 1'b0, ns, sc);
      run_frame(16'h1000, 1'b0, ns, sc);
      repeat (7) @(negedge clk);
      rst = 1'b0; #1;
      chk("midrst_rkey", rkey, 4'b1110);
      chk("midrst_code", key_code, 0);
      chk("midrst_held", key_held, 0);
      @(negedge clk); rst = 1'b1;
      model_reset();
      for (int f = 0; f < 3; f++) begin
         e = model_frame(16'h1000);
         run_frame(16'h1000, 1'b0, ns, sc);
         chk("postrst_stb", ns, (f == 2) ? 1 : 0);
      end
      chk("postrst_code", key_code, 12);
      for (int f = 0; f < 3; f++) begin e = model_frame(16'h0); run_frame(16'h0, 1'b0, ns, sc); end
      chk("postrst_rel", key_held, 0);

      // Random frame patterns against the reference model
      for (int burst = 0; burst < 30; burst++) begin
         a = $urandom_range(0, 99);
         p = 16'h0;
         if (a >= 40) p[$urandom_range(0, 15)] = 1'b1;
         if (a >= 85) begin
            b = $urandom_range(0, 15);
            while (p[b]) b = $urandom_range(0, 15);
            p[b] = 1'b1;
         end
         len = $urandom_range(1, 5);
         for (int f = 0; f < len; f++) begin
            e = model_frame(p);
            run_frame(p, 1'b0, ns, sc);
            chk("rnd_stb", ns, e);
            chk("rnd_held", key_held, m_held);
            chk("rnd_code", key_code, m_code);
         end
      end
      for (int f = 0; f < 3; f++) begin e = model_frame(16'h0); run_frame(16'h0, 1'b0, ns, sc); end
      chk("rnd_idle", key_held, 0);

      // Long hold of key 15: acceptance plus auto-repeat when enabled
      tot = 0;
      for (int f = 0; f < 13; f++) begin
         e = model_frame(16'h8000);
         run_frame(16'h8000, 1'b0, ns, sc);
         chk("hold_stb", ns, e);
         if (ns > 0) chk("hold_code", sc, 15);
         tot += ns;
      end
`ifdef KEYPAD_AUTO_REPEAT_EN
      chk("hold_total", tot, 5);
`else
      chk("hold_total", tot, 1);
`endif
      for (int f = 0; f < 3; f++) begin e = model_frame(16'h0); run_frame(16'h0, 1'b0, ns, sc); end
      chk("hold_release", key_held, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
